// File: rtl/regdst_pkg.sv
// regdst_pkg: select encodings, return-address register, stage record and width helper for regdst_pipe
package regdst_pkg;
  localparam int SEL_RT = 0;
  localparam int SEL_RD = 1;
  localparam int SEL_RA = 2;
  localparam int RA_ADDR = 31;
  localparam int DEST_W = 5;
  typedef struct packed {
    logic valid;
    logic we;
    logic [DEST_W-1:0] dest;
  } stage_t;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/regdst_mux.sv
// regdst_mux: NUM_IN-way destination mux; out-of-range select yields 0 with sel_ok low
module regdst_mux #(
  parameter int ADDR_W = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_IN*ADDR_W-1:0] in_bus,
  output logic [ADDR_W-1:0]        dout,
  output logic                     sel_ok
);
  always_comb begin
    dout = '0;
    for (int k = 0; k < NUM_IN; k++) dout = (sel == SEL_W'(k)) ? in_bus[k*ADDR_W +: ADDR_W] : dout;
  end
  assign sel_ok = 32'(sel) < NUM_IN;
endmodule

// File: rtl/regdst_pipe.sv
// regdst_pipe: destination select, in-flight writer tracker, RAW hazard detect (optional REGDST_FWD_EN forwarding split)
module regdst_pipe import regdst_pkg::*; #(
  parameter int ADDR_W = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W = clog2(NUM_IN),
  parameter int DEPTH = 3,
  parameter int IDX_W = clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_we,
  input  logic [SEL_W-1:0]         RegDst,
  input  logic [NUM_IN*ADDR_W-1:0] in_bus,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        rs_a,
  input  logic [ADDR_W-1:0]        rs_b,
  output logic                     haz_a,
  output logic [IDX_W-1:0]         haz_a_idx,
  output logic                     haz_b,
  output logic [IDX_W-1:0]         haz_b_idx,
  output logic                     wb_we,
  output logic [ADDR_W-1:0]        wb_dest,
  output logic                     sel_err
`ifdef REGDST_FWD_EN
  ,
  output logic                     fwd_a_dest_valid,
  output logic                     fwd_b_dest_valid
`endif
);
  typedef struct packed {
    logic valid;
    logic we;
    logic [ADDR_W-1:0] dest;
  } stg_t;
  stg_t stg [DEPTH];
  logic [ADDR_W-1:0] dest_in;
  logic sel_ok;
  logic [DEPTH-1:0] hit_a, hit_b;
  regdst_mux #(.ADDR_W(ADDR_W), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_mux (
    .sel(RegDst),
    .in_bus(in_bus),
    .dout(dest_in),
    .sel_ok(sel_ok)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
      sel_err <= 1'b0;
    end else begin
      if (flush) stg[0] <= '0;
      else if (!stall) stg[0] <= '{in_valid, in_valid & in_we & sel_ok, dest_in};
      for (int i = 1; i < DEPTH; i++) stg[i] <= (i == 1 && stall) ? '0 : stg[i-1];
      sel_err <= in_valid & ~sel_ok & ~stall & ~flush;
    end
  end
  function automatic logic [IDX_W-1:0] youngest(input logic [DEPTH-1:0] h);
    youngest = '0;
    for (int i = DEPTH - 1; i >= 0; i--) youngest = h[i] ? IDX_W'(i) : youngest;
  endfunction
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_a[i] = stg[i].valid & stg[i].we & (stg[i].dest == rs_a) & (|rs_a);
      hit_b[i] = stg[i].valid & stg[i].we & (stg[i].dest == rs_b) & (|rs_b);
    end
  end
  assign haz_a_idx = youngest(hit_a);
  assign haz_b_idx = youngest(hit_b);
`ifdef REGDST_FWD_EN
  localparam logic [DEPTH-1:0] NEAR = DEPTH'(3);
  assign fwd_a_dest_valid = |(hit_a & NEAR);
  assign fwd_b_dest_valid = |(hit_b & NEAR);
  assign haz_a = |hit_a & ~fwd_a_dest_valid;
  assign haz_b = |hit_b & ~fwd_b_dest_valid;
`else
  assign haz_a = |hit_a;
  assign haz_b = |hit_b;
`endif
  assign wb_we = stg[DEPTH-1].valid & stg[DEPTH-1].we;
  assign wb_dest = stg[DEPTH-1].dest;
endmodule

// File: tb/tb_regdst_pipe.sv
// tb_regdst_pipe: scoreboard bench for regdst_pipe (NUM_IN=3, DEPTH=3), aware of REGDST_FWD_EN
module tb_regdst_pipe;
  logic clk = 1'b0;
  logic reset, in_valid, in_we, stall, flush;
  logic [1:0] RegDst;
  logic [14:0] in_bus;
  logic [4:0] rs_a, rs_b, wb_dest;
  logic haz_a, haz_b, wb_we, sel_err;
  logic [1:0] haz_a_idx, haz_b_idx;
`ifdef REGDST_FWD_EN
  logic fwd_a_dest_valid, fwd_b_dest_valid;
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct {
    int due;
    logic we;
    logic [4:0] dest;
  } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  regdst_pipe #(.ADDR_W(5), .NUM_IN(3), .SEL_W(2), .DEPTH(3), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_we(in_we), .RegDst(RegDst),
    .in_bus(in_bus), .stall(stall), .flush(flush), .rs_a(rs_a), .rs_b(rs_b),
    .haz_a(haz_a), .haz_a_idx(haz_a_idx), .haz_b(haz_b), .haz_b_idx(haz_b_idx),
    .wb_we(wb_we), .wb_dest(wb_dest), .sel_err(sel_err)
`ifdef REGDST_FWD_EN
    , .fwd_a_dest_valid(fwd_a_dest_valid), .fwd_b_dest_valid(fwd_b_dest_valid)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic v, input logic we, input logic [1:0] sel, input logic [4:0] rt,
                       input logic ew, input logic [4:0] ed, input int dly);
    in_valid = v;
    in_we = we;
    RegDst = sel;
    in_bus = {5'd31, 5'd9, rt};
    sb.push_back('{due: cyc + dly, we: ew, dest: ed});
    step();
  endtask
  task automatic chk_a(input logic h, input logic [1:0] idx, input logic near);
    chk("haz_a", haz_a, h & ~(FWD & near));
    chk("haz_a_idx", haz_a_idx, idx);
`ifdef REGDST_FWD_EN
    chk("fwd_a", fwd_a_dest_valid, h & near);
`endif
  endtask
  task automatic chk_b(input logic h, input logic [1:0] idx, input logic near);
    chk("haz_b", haz_b, h & ~(FWD & near));
    chk("haz_b_idx", haz_b_idx, idx);
`ifdef REGDST_FWD_EN
    chk("fwd_b", fwd_b_dest_valid, h & near);
`endif
  endtask
  always @(negedge clk) begin
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL wb_missed: entry due at cycle %0d unchecked at cycle %0d", sb[k].due, cyc);
        sb.delete(k);
      end else if (sb[k].due == cyc) begin
        chk("wb_we", wb_we, sb[k].we);
        if (sb[k].we) chk("wb_dest", wb_dest, sb[k].dest);
        sb.delete(k);
      end
    end
  end
  initial begin
    reset = 1'b1;
    in_valid = 1'b1;
    in_we = 1'b1;
    RegDst = 2'd0;
    in_bus = {5'd31, 5'd9, 5'd8};
    stall = 1'b0;
    flush = 1'b0;
    rs_a = 5'd8;
    rs_b = 5'd9;
    step();
    step();
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_sel_err", sel_err, 0);
    chk_a(1'b0, 2'd0, 1'b0);
    chk_b(1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    issue(1, 1, 2'd0, 5'd8, 1, 5'd8, 3);
    issue(1, 1, 2'd1, 5'd8, 1, 5'd9, 3);
    issue(1, 1, 2'd2, 5'd8, 1, 5'd31, 3);
    issue(1, 1, 2'd3, 5'd8, 0, 5'd0, 3);
    chk("sel_err_pulse", sel_err, 1);
    issue(0, 0, 2'd0, 5'd8, 0, 5'd0, 3);
    chk("sel_err_clear", sel_err, 0);
    issue(1, 1, 2'd0, 5'd5, 1, 5'd5, 3);
    issue(1, 1, 2'd0, 5'd7, 1, 5'd7, 3);
    issue(1, 1, 2'd0, 5'd5, 1, 5'd5, 3);
    rs_a = 5'd5;
    rs_b = 5'd7;
    #1;
    chk_a(1'b1, 2'd0, 1'b1);
    chk_b(1'b1, 2'd1, 1'b1);
    issue(1, 1, 2'd0, 5'd0, 1, 5'd0, 3);
    rs_b = 5'd0;
    #1;
    chk_a(1'b1, 2'd1, 1'b1);
    chk_b(1'b0, 2'd0, 1'b0);
    rs_a = 5'd7;
    #1;
    chk_a(1'b1, 2'd2, 1'b0);
    rs_a = 5'd3;
    #1;
    chk_a(1'b0, 2'd0, 1'b0);
    issue(1, 1, 2'd0, 5'd12, 1, 5'd12, 5);
    rs_a = 5'd12;
    stall = 1'b1;
    issue(1, 1, 2'd0, 5'd13, 0, 5'd0, 2);
    chk_a(1'b1, 2'd0, 1'b1);
    issue(1, 1, 2'd0, 5'd13, 0, 5'd0, 2);
    chk_a(1'b1, 2'd0, 1'b1);
    stall = 1'b0;
    issue(1, 1, 2'd0, 5'd13, 1, 5'd13, 3);
    chk_a(1'b1, 2'd1, 1'b1);
    issue(1, 1, 2'd0, 5'd20, 1, 5'd20, 3);
    issue(1, 1, 2'd0, 5'd21, 0, 5'd0, 3);
    flush = 1'b1;
    stall = 1'b1;
    issue(1, 1, 2'd3, 5'd22, 0, 5'd0, 3);
    flush = 1'b0;
    stall = 1'b0;
    chk("flush_sel_err", sel_err, 0);
    rs_a = 5'd21;
    rs_b = 5'd20;
    #1;
    chk_a(1'b0, 2'd0, 1'b0);
    chk_b(1'b1, 2'd2, 1'b0);
    in_valid = 1'b0;
    for (int n = 0; n < 10 && sb.size() > 0; n++) step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expected writebacks never checked", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
